// File: rtl/str_timing_capture_monitor.sv
// Multi-channel strobe-qualified capture register with cycle-based setup, hold,
// strobe-width and strobe-period checks, sticky violation flags and a saturating
// violation event counter.
module str_timing_capture_monitor #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned MIN_WIDTH  = 2,
  parameter int unsigned MIN_PERIOD = 5,
  parameter logic [3:0]  CHECK_EN   = 4'b1111,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       strobe,
  input  logic                      viol_clr,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       valid_out,
  output logic [CHANNELS-1:0]       viol_setup,
  output logic [CHANNELS-1:0]       viol_hold,
  output logic [CHANNELS-1:0]       viol_width,
  output logic [CHANNELS-1:0]       viol_period,
  output logic [CNT_W-1:0]          viol_count
);

  localparam int unsigned SW   = $clog2(SETUP_CYC + 1);
  localparam int unsigned HW   = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam int unsigned WW   = $clog2(MIN_WIDTH + 1);
  localparam int unsigned PW   = $clog2(MIN_PERIOD + 1);
  localparam int unsigned EW   = $clog2(4 * CHANNELS + 1);
  localparam int unsigned SUMW = ((CNT_W > EW) ? CNT_W : EW) + 1;

  localparam logic [SW-1:0] SETUP_V  = SW'(SETUP_CYC);
  localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_CYC);
  localparam logic [WW-1:0] WIDTH_V  = WW'(MIN_WIDTH);
  localparam logic [PW-1:0] PERIOD_V = PW'(MIN_PERIOD);

  logic [CHANNELS-1:0]       r_strobe_q;
  logic [CHANNELS*WIDTH-1:0] r_data_q;
  logic [CHANNELS*WIDTH-1:0] r_data_out;
  logic [CHANNELS-1:0]       r_valid;
  logic [CHANNELS-1:0]       r_seen_rise;
  logic [CHANNELS-1:0]       r_v_setup, r_v_hold, r_v_width, r_v_period;
  logic [CNT_W-1:0]          r_count;
  logic [SW-1:0]             r_stab     [CHANNELS];
  logic [HW-1:0]             r_hold_cnt [CHANNELS];
  logic [WW-1:0]             r_high     [CHANNELS];
  logic [PW-1:0]             r_per      [CHANNELS];

  logic [CHANNELS-1:0]       w_rise, w_fall;
  logic [CHANNELS-1:0]       w_ev_setup, w_ev_hold, w_ev_width, w_ev_period;
  logic [SW-1:0]             w_stab_d     [CHANNELS];
  logic [HW-1:0]             w_hold_cnt_d [CHANNELS];
  logic [WW-1:0]             w_high_d     [CHANNELS];
  logic [PW-1:0]             w_per_d      [CHANNELS];
  logic [EW-1:0]             w_pop;
  logic [SUMW-1:0]           w_sum;
  logic [CNT_W-1:0]          w_count_d;

  // Per-channel edge detect, counter next-state and gated violation events
  always_comb begin
    w_rise       = '0;
    w_fall       = '0;
    w_ev_setup   = '0;
    w_ev_hold    = '0;
    w_ev_width   = '0;
    w_ev_period  = '0;
    w_stab_d     = r_stab;
    w_hold_cnt_d = r_hold_cnt;
    w_high_d     = r_high;
    w_per_d      = r_per;
    for (int c = 0; c < CHANNELS; c++) begin
      w_rise[c] = strobe[c] & ~r_strobe_q[c];
      w_fall[c] = ~strobe[c] & r_strobe_q[c];

      // Run length of unchanged data, including the current cycle
      if (data_in[c*WIDTH +: WIDTH] == r_data_q[c*WIDTH +: WIDTH]) begin
        w_stab_d[c] = (r_stab[c] >= SETUP_V) ? SETUP_V : r_stab[c] + SW'(1);
      end else begin
        w_stab_d[c] = SW'(1);
      end
      w_ev_setup[c] = CHECK_EN[0] & w_rise[c] & (w_stab_d[c] < SETUP_V);

      // data_out holds the last captured value, so it doubles as the hold reference
      if (w_rise[c]) begin
        w_hold_cnt_d[c] = HOLD_V;
      end else if (r_hold_cnt[c] != '0) begin
        w_ev_hold[c]    = CHECK_EN[1] &
                          (data_in[c*WIDTH +: WIDTH] != r_data_out[c*WIDTH +: WIDTH]);
        w_hold_cnt_d[c] = r_hold_cnt[c] - HW'(1);
      end

      if (w_rise[c]) begin
        w_high_d[c] = WW'(1);
      end else if (strobe[c]) begin
        w_high_d[c] = (r_high[c] >= WIDTH_V) ? WIDTH_V : r_high[c] + WW'(1);
      end else begin
        w_high_d[c] = '0;
      end
      w_ev_width[c] = CHECK_EN[2] & w_fall[c] & (r_high[c] < WIDTH_V);

      if (w_rise[c]) begin
        w_per_d[c] = PW'(1);
      end else begin
        w_per_d[c] = (r_per[c] >= PERIOD_V) ? PERIOD_V : r_per[c] + PW'(1);
      end
      w_ev_period[c] = CHECK_EN[3] & w_rise[c] & r_seen_rise[c] & (r_per[c] < PERIOD_V);
    end
  end

  // Popcount of this cycle's events and saturating counter update; clear loses to events
  always_comb begin
    w_pop = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_pop = w_pop + EW'(w_ev_setup[c]) + EW'(w_ev_hold[c]) +
              EW'(w_ev_width[c]) + EW'(w_ev_period[c]);
    end
    w_sum     = (viol_clr ? '0 : SUMW'(r_count)) + SUMW'(w_pop);
    w_count_d = (w_sum[SUMW-1:CNT_W] != '0) ? '1 : w_sum[CNT_W-1:0];
  end

  // Channel state, capture and sticky flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe_q  <= '0;
      r_data_q    <= '0;
      r_data_out  <= '0;
      r_valid     <= '0;
      r_seen_rise <= '0;
      r_v_setup   <= '0;
      r_v_hold    <= '0;
      r_v_width   <= '0;
      r_v_period  <= '0;
      r_count     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_stab[c]     <= '0;
        r_hold_cnt[c] <= '0;
        r_high[c]     <= '0;
        r_per[c]      <= '0;
      end
    end else begin
      r_strobe_q <= strobe;
      r_data_q   <= data_in;
      r_valid    <= w_rise;
      r_v_setup  <= w_ev_setup  | (r_v_setup  & ~{CHANNELS{viol_clr}});
      r_v_hold   <= w_ev_hold   | (r_v_hold   & ~{CHANNELS{viol_clr}});
      r_v_width  <= w_ev_width  | (r_v_width  & ~{CHANNELS{viol_clr}});
      r_v_period <= w_ev_period | (r_v_period & ~{CHANNELS{viol_clr}});
      r_count    <= w_count_d;
      for (int c = 0; c < CHANNELS; c++) begin
        r_stab[c]     <= w_stab_d[c];
        r_hold_cnt[c] <= w_hold_cnt_d[c];
        r_high[c]     <= w_high_d[c];
        r_per[c]      <= w_per_d[c];
        if (w_rise[c]) begin
          r_data_out[c*WIDTH +: WIDTH] <= data_in[c*WIDTH +: WIDTH];
          r_seen_rise[c]               <= 1'b1;
        end
      end
    end
  end

  assign data_out    = r_data_out;
  assign valid_out   = r_valid;
  assign viol_setup  = r_v_setup;
  assign viol_hold   = r_v_hold;
  assign viol_width  = r_v_width;
  assign viol_period = r_v_period;
  assign viol_count  = r_count;

endmodule

// File: tb/tb_str_timing_capture_monitor.sv
// Self-checking bench: two instances (default, and CHECK_EN=4'b1101 with CNT_W=2)
// share stimulus and are compared against a timestamp-based reference model.
module tb_str_timing_capture_monitor;

  localparam int W     = 8;
  localparam int CH    = 2;
  localparam int SETUP = 2;
  localparam int HOLD  = 1;
  localparam int MINW  = 2;
  localparam int MINP  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH*W-1:0] data_in;
  logic [CH-1:0] strobe;
  logic          viol_clr;

  logic [CH*W-1:0] m_data_out, n_data_out;
  logic [CH-1:0] m_valid_out, m_viol_setup, m_viol_hold, m_viol_width, m_viol_period;
  logic [CH-1:0] n_valid_out, n_viol_setup, n_viol_hold, n_viol_width, n_viol_period;
  logic [7:0]    m_viol_count;
  logic [1:0]    n_viol_count;

  str_timing_capture_monitor u_dut_m (
    .clk(clk), .rst(rst), .data_in(data_in), .strobe(strobe), .viol_clr(viol_clr),
    .data_out(m_data_out), .valid_out(m_valid_out), .viol_setup(m_viol_setup),
    .viol_hold(m_viol_hold), .viol_width(m_viol_width), .viol_period(m_viol_period),
    .viol_count(m_viol_count)
  );

  str_timing_capture_monitor #(.CHECK_EN(4'b1101), .CNT_W(2)) u_dut_n (
    .clk(clk), .rst(rst), .data_in(data_in), .strobe(strobe), .viol_clr(viol_clr),
    .data_out(n_data_out), .valid_out(n_valid_out), .viol_setup(n_viol_setup),
    .viol_hold(n_viol_hold), .viol_width(n_viol_width), .viol_period(n_viol_period),
    .viol_count(n_viol_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: timestamps since reset instead of counters
  int          cyc;
  int          chg       [CH];
  int          last_rise [CH];
  int          hold_end  [CH];
  logic [W-1:0] prev_d   [CH];
  logic        prev_s    [CH];
  logic [W-1:0] cap      [CH];
  logic [CH-1:0] e_valid;
  logic [CH-1:0] e_flag  [2][4];
  int          e_cnt     [2];
  logic [3:0]  en        [2];
  int          cmax      [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    e_valid = '0;
    for (int c = 0; c < CH; c++) begin
      chg[c] = 0; last_rise[c] = -1; hold_end[c] = -1;
      prev_d[c] = '0; prev_s[c] = 1'b0; cap[c] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      e_cnt[k] = 0;
      for (int t = 0; t < 4; t++) e_flag[k][t] = '0;
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] ev [2][4];
    int pop [2];
    for (int k = 0; k < 2; k++) begin
      pop[k] = 0;
      for (int t = 0; t < 4; t++) ev[k][t] = '0;
    end
    for (int c = 0; c < CH; c++) begin
      logic [W-1:0] d;
      logic s, rise, fall;
      logic [3:0] raw;
      d = data_in[c*W +: W];
      s = strobe[c];
      if (cyc == 0 || d != prev_d[c]) chg[c] = cyc;
      rise = s && !prev_s[c];
      fall = !s && prev_s[c];
      raw[0] = rise && ((cyc - chg[c] + 1) < SETUP);
      raw[1] = !rise && (cyc <= hold_end[c]) && (d != cap[c]);
      raw[2] = fall && ((cyc - last_rise[c]) < MINW);
      raw[3] = rise && (last_rise[c] >= 0) && ((cyc - last_rise[c]) < MINP);
      for (int k = 0; k < 2; k++)
        for (int t = 0; t < 4; t++)
          if (raw[t] && en[k][t]) begin
            ev[k][t][c] = 1'b1;
            pop[k]++;
          end
      e_valid[c] = rise;
      if (rise) begin
        cap[c] = d; hold_end[c] = cyc + HOLD; last_rise[c] = cyc;
      end
      prev_s[c] = s;
      prev_d[c] = d;
    end
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 4; t++)
        e_flag[k][t] = ev[k][t] | (e_flag[k][t] & ~{CH{viol_clr}});
      e_cnt[k] = (viol_clr ? 0 : e_cnt[k]) + pop[k];
      if (e_cnt[k] > cmax[k]) e_cnt[k] = cmax[k];
    end
    cyc++;
  endtask

  function automatic logic [CH*W-1:0] exp_data();
    logic [CH*W-1:0] v;
    for (int c = 0; c < CH; c++) v[c*W +: W] = cap[c];
    return v;
  endfunction

  task automatic compare_all();
    check("m.data_out", m_data_out, exp_data());
    check("m.valid", m_valid_out, e_valid);
    check("m.setup", m_viol_setup, e_flag[0][0]);
    check("m.hold", m_viol_hold, e_flag[0][1]);
    check("m.width", m_viol_width, e_flag[0][2]);
    check("m.period", m_viol_period, e_flag[0][3]);
    check("m.count", m_viol_count, e_cnt[0]);
    check("n.data_out", n_data_out, exp_data());
    check("n.valid", n_valid_out, e_valid);
    check("n.setup", n_viol_setup, e_flag[1][0]);
    check("n.hold", n_viol_hold, e_flag[1][1]);
    check("n.width", n_viol_width, e_flag[1][2]);
    check("n.period", n_viol_period, e_flag[1][3]);
    check("n.count", n_viol_count, e_cnt[1]);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drv(input logic [W-1:0] d0, input logic [W-1:0] d1,
                     input logic [1:0] s, input logic clr);
    data_in  = {d1, d0};
    strobe   = s;
    viol_clr = clr;
    step();
  endtask

  // Asserted between edges so the zeroed outputs are checked before any clock edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    en[0] = 4'b1111; cmax[0] = 255;
    en[1] = 4'b1101; cmax[1] = 3;
    rst = 1'b1; data_in = '0; strobe = '0; viol_clr = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean capture: setup, width and period all met
    drv(8'hA5, 8'h00, 2'b00, 0); drv(8'hA5, 8'h00, 2'b00, 0);
    drv(8'hA5, 8'h00, 2'b01, 0); drv(8'hA5, 8'h00, 2'b01, 0);
    for (int i = 0; i < 4; i++) drv(8'hA5, 8'h00, 2'b00, 0);
    drv(8'hA5, 8'h00, 2'b01, 0); drv(8'hA5, 8'h00, 2'b01, 0);
    drv(8'hA5, 8'h00, 2'b00, 0);
    check("s1.data", m_data_out[7:0], 8'hA5);
    check("s1.count", m_viol_count, 0);

    // Data changes on the rise cycle
    do_reset();
    drv(8'h3C, 8'h00, 2'b00, 0); drv(8'h3C, 8'h00, 2'b00, 0);
    drv(8'h5A, 8'h00, 2'b01, 0); drv(8'h5A, 8'h00, 2'b01, 0);
    drv(8'h5A, 8'h00, 2'b00, 0);
    check("s2.setup", m_viol_setup[0], 1'b1);
    check("s2.count", m_viol_count, 1);
    check("s2.data", m_data_out[7:0], 8'h5A);

    // ch1 data changes one cycle after the rise
    do_reset();
    drv(8'h00, 8'h11, 2'b00, 0); drv(8'h00, 8'h11, 2'b00, 0);
    drv(8'h00, 8'h11, 2'b10, 0); drv(8'h00, 8'h22, 2'b10, 0);
    drv(8'h00, 8'h22, 2'b00, 0);
    check("s3.hold_m", m_viol_hold[1], 1'b1);
    check("s3.hold_n", n_viol_hold[1], 1'b0);

    // Narrow pulse followed by an early second rise
    do_reset();
    drv(0, 0, 2'b00, 0); drv(0, 0, 2'b00, 0); drv(0, 0, 2'b01, 0); drv(0, 0, 2'b00, 0);
    drv(0, 0, 2'b00, 0); drv(0, 0, 2'b01, 0); drv(0, 0, 2'b01, 0); drv(0, 0, 2'b00, 0);
    check("s4.width", m_viol_width[0], 1'b1);
    check("s4.period", m_viol_period[0], 1'b1);
    check("s4.count", m_viol_count, 2);

    // Event storm saturates the 2-bit counter, then reset inside a hold window
    do_reset();
    for (int i = 0; i < 6; i++)
      drv(8'(i), 8'(i + 7), (i % 2 == 0) ? 2'b11 : 2'b00, 0);
    check("s6.sat", n_viol_count, 2'd3);
    drv(8'h10, 8'h00, 2'b01, 0);
    do_reset();
    drv(8'h10, 8'h00, 2'b00, 0); drv(8'h10, 8'h00, 2'b01, 0);
    drv(8'h10, 8'h00, 2'b01, 0);
    check("s6.period", m_viol_period[0], 1'b0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] d0, d1;
      logic [1:0] s;
      if ($urandom_range(0, 499) == 0) do_reset();
      d0 = data_in[W-1:0];
      d1 = data_in[2*W-1:W];
      s  = strobe;
      if ($urandom_range(0, 2) == 0) d0 = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) d1 = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) s[0] = ~s[0];
      if ($urandom_range(0, 2) == 0) s[1] = ~s[1];
      drv(d0, d1, s, ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
